// File: rtl/clock_pkg.sv
// Shared constants and helpers for the chess-clock BCD datapath.
package clock_pkg;
  localparam int BCD_W = 4;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Values above the digit limit, including non-BCD codes, saturate to the limit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] val,
                                                 input logic [BCD_W-1:0] max_v);
    return (val > max_v) ? max_v : val;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with its own roll-over limit; carry/borrow ripples combinationally.
module bcd_digit_cell
  import clock_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_ce,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_nib,
  input  logic [BCD_W-1:0] i_max,
  input  logic             i_step,
  input  logic             i_dir,
  input  logic             i_cin,
  input  logic             i_adj_inc,
  input  logic             i_adj_dec,
  output logic [BCD_W-1:0] o_count,
  output logic             o_cout
);
  logic [BCD_W-1:0] r_count;
  logic             w_at_zero;
  logic             w_at_max;
  logic [BCD_W-1:0] w_inc_val;
  logic [BCD_W-1:0] w_dec_val;
  logic [BCD_W-1:0] w_step_val;
  logic [BCD_W-1:0] w_adj_val;

  assign w_at_zero  = (r_count == '0);
  assign w_at_max   = (r_count == i_max);
  assign w_inc_val  = w_at_max  ? '0    : r_count + 4'd1;
  assign w_dec_val  = w_at_zero ? i_max : r_count - 4'd1;
  assign w_step_val = (i_dir == DIR_DOWN) ? w_dec_val : w_inc_val;
  assign w_adj_val  = i_adj_inc ? w_inc_val : w_dec_val;

  assign o_cout  = i_step & i_cin & ((i_dir == DIR_DOWN) ? w_at_zero : w_at_max);
  assign o_count = r_count;

  // A tick cycle swallows any adjust on this digit even when no carry arrives.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= bcd_clamp(i_load_nib, i_max);
    end else if (i_step) begin
      if (i_cin) r_count <= w_step_val;
    end else if (i_ce && (i_adj_inc ^ i_adj_dec)) begin
      r_count <= w_adj_val;
    end
  end
endmodule

// File: rtl/bcd_time_counter.sv
// Multi-digit BCD up/down time counter with preset, per-digit adjust, wrap and expiry flags.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int                    DIGITS   = 4,
  parameter logic [4*DIGITS-1:0]   MAX_VEC  = 16'h5959,
  parameter bit                    SATURATE = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_ce,
  input  logic                  i_tick,
  input  logic                  i_dir,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  input  logic [DIGITS-1:0]     i_adj_inc,
  input  logic [DIGITS-1:0]     i_adj_dec,
  output logic [4*DIGITS-1:0]   o_digit_out,
  output logic                  o_zero,
  output logic                  o_wrap,
  output logic                  o_expired
);
  localparam logic [4*DIGITS-1:0] COUNT_ONE = (4*DIGITS)'(1);

  logic [4*DIGITS-1:0] w_count;
  logic [DIGITS:0]     w_carry;
  logic                w_tick;
  logic                w_zero;
  logic                w_hold;
  logic                w_to_zero;
  logic                r_wrap;
  logic                r_expired;

  assign w_tick = i_ce & i_tick;
  assign w_zero = (w_count == '0);
  // Saturating down-count at zero: kill the ripple at its source so nothing moves.
  assign w_hold     = SATURATE && (i_dir == DIR_DOWN) && w_zero;
  assign w_carry[0] = ~w_hold;
  assign w_to_zero  = (w_count == COUNT_ONE) || w_hold;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .i_clk      (i_clk),
      .i_clr      (i_clr),
      .i_ce       (i_ce),
      .i_load     (i_load),
      .i_load_nib (i_load_val[g*BCD_W +: BCD_W]),
      .i_max      (MAX_VEC[g*BCD_W +: BCD_W]),
      .i_step     (w_tick),
      .i_dir      (i_dir),
      .i_cin      (w_carry[g]),
      .i_adj_inc  (i_adj_inc[g]),
      .i_adj_dec  (i_adj_dec[g]),
      .o_count    (w_count[g*BCD_W +: BCD_W]),
      .o_cout     (w_carry[g+1])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_clr || i_load) begin
      r_wrap    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_wrap <= w_carry[DIGITS];
      if (w_tick && (i_dir == DIR_DOWN) && w_to_zero) r_expired <= 1'b1;
    end
  end

  assign o_digit_out = w_count;
  assign o_zero      = w_zero;
  assign o_wrap      = r_wrap;
  assign o_expired   = r_expired;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench: vector table on a saturating counter plus hand sequences on a wrapping one.
module tb_bcd_time_counter;
  logic        clk = 1'b0;
  logic        clr, ce, tick, dir, load;
  logic [15:0] load_val;
  logic [3:0]  adj_inc, adj_dec;
  logic [15:0] s_dig, w_dig;
  logic        s_zero, s_wrap, s_exp, w_zero, w_wrap, w_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.DIGITS(4), .MAX_VEC(16'h5959), .SATURATE(1'b1)) dut_s (
    .i_clk(clk), .i_clr(clr), .i_ce(ce), .i_tick(tick), .i_dir(dir), .i_load(load),
    .i_load_val(load_val), .i_adj_inc(adj_inc), .i_adj_dec(adj_dec),
    .o_digit_out(s_dig), .o_zero(s_zero), .o_wrap(s_wrap), .o_expired(s_exp));

  bcd_time_counter #(.DIGITS(4), .MAX_VEC(16'h5959), .SATURATE(1'b0)) dut_w (
    .i_clk(clk), .i_clr(clr), .i_ce(ce), .i_tick(tick), .i_dir(dir), .i_load(load),
    .i_load_val(load_val), .i_adj_inc(adj_inc), .i_adj_dec(adj_dec),
    .o_digit_out(w_dig), .o_zero(w_zero), .o_wrap(w_wrap), .o_expired(w_exp));

  typedef struct {
    logic        clr, load, ce, tick, dir;
    logic [15:0] lval;
    logic [3:0]  inc, dec;
    logic [15:0] e_dig;
    logic        e_wrap, e_exp, e_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic l, input logic [15:0] lv, input logic e,
                     input logic t, input logic d, input logic [3:0] ai, input logic [3:0] ad,
                     input logic [15:0] xd, input logic xw, input logic xe, input logic xz);
    vec_t v;
    v.clr = c; v.load = l; v.lval = lv; v.ce = e; v.tick = t; v.dir = d;
    v.inc = ai; v.dec = ad; v.e_dig = xd; v.e_wrap = xw; v.e_exp = xe; v.e_zero = xz;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic c, input logic l, input logic [15:0] lv, input logic e,
                      input logic t, input logic d, input logic [3:0] ai, input logic [3:0] ad);
    clr = c; load = l; load_val = lv; ce = e; tick = t; dir = d; adj_inc = ai; adj_dec = ad;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; load = 1'b0; load_val = '0; ce = 1'b0; tick = 1'b0; dir = 1'b0;
    adj_inc = '0; adj_dec = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    //  clr load lval    ce tick dir inc     dec      digits  wrap exp zero
    add(1, 0, 16'h0000, 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, 0, 0, 1);
    add(0, 1, 16'h5958, 1, 0, 0, 4'b0000, 4'b0000, 16'h5958, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000, 16'h5959, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000, 16'h0000, 1, 0, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, 0, 0, 1);
    add(0, 1, 16'h0002, 1, 0, 0, 4'b0000, 4'b0000, 16'h0002, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 1, 4'b0000, 4'b0000, 16'h0001, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 1, 4'b0000, 4'b0000, 16'h0000, 0, 1, 1);
    add(0, 0, 16'h0000, 1, 1, 1, 4'b0000, 4'b0000, 16'h0000, 0, 1, 1);
    add(0, 1, 16'h1000, 1, 0, 0, 4'b0000, 4'b0000, 16'h1000, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 4'b0000, 4'b0011, 16'h1059, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 4'b0011, 4'b0010, 16'h1050, 0, 0, 0);
    add(0, 1, 16'h7AF3, 1, 0, 0, 4'b0000, 4'b0000, 16'h5953, 0, 0, 0);
    add(0, 1, 16'h0100, 1, 1, 0, 4'b0000, 4'b0000, 16'h0100, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 0, 4'b0000, 4'b0000, 16'h0100, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 0, 4'b0001, 4'b0000, 16'h0100, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 4'b0100, 4'b0000, 16'h0101, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000, 16'h0102, 0, 0, 0);
    add(1, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000, 16'h0000, 0, 0, 1);
    add(0, 1, 16'h0959, 1, 0, 0, 4'b0000, 4'b0000, 16'h0959, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000, 16'h1000, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 1, 4'b0000, 4'b0000, 16'h0959, 0, 0, 0);
    add(0, 1, 16'h0000, 1, 0, 0, 4'b0000, 4'b0000, 16'h0000, 0, 0, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 4'b0001, 4'b0000, 16'h0001, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 4'b0000, 4'b0001, 16'h0000, 0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].load, vecs[i].lval, vecs[i].ce, vecs[i].tick, vecs[i].dir,
           vecs[i].inc, vecs[i].dec);
      chk($sformatf("vec%0d digits", i), s_dig, vecs[i].e_dig);
      chk($sformatf("vec%0d wrap", i), {15'd0, s_wrap}, {15'd0, vecs[i].e_wrap});
      chk($sformatf("vec%0d expired", i), {15'd0, s_exp}, {15'd0, vecs[i].e_exp});
      chk($sformatf("vec%0d zero", i), {15'd0, s_zero}, {15'd0, vecs[i].e_zero});
    end

    // Wrapping variant: borrow out of zero, then back-to-back wrap on an up tick.
    step(0, 1, 16'h0001, 1, 0, 0, 4'b0000, 4'b0000);
    chk("w load 0001", w_dig, 16'h0001);
    step(0, 0, 16'h0000, 1, 1, 1, 4'b0000, 4'b0000);
    chk("w down to zero", w_dig, 16'h0000);
    chk("w expired set", {15'd0, w_exp}, 16'd1);
    step(0, 0, 16'h0000, 1, 1, 1, 4'b0000, 4'b0000);
    chk("w borrow wrap digits", w_dig, 16'h5959);
    chk("w borrow wrap pulse", {15'd0, w_wrap}, 16'd1);
    chk("w expired sticky", {15'd0, w_exp}, 16'd1);
    chk("s saturate digits", s_dig, 16'h0000);
    chk("s saturate wrap", {15'd0, s_wrap}, 16'd0);
    step(0, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000);
    chk("w up wrap digits", w_dig, 16'h0000);
    chk("w back-to-back wrap", {15'd0, w_wrap}, 16'd1);
    chk("w expired after up", {15'd0, w_exp}, 16'd1);
    chk("s up from zero", s_dig, 16'h0001);
    step(0, 0, 16'h0000, 1, 0, 0, 4'b0000, 4'b0000);
    chk("w wrap one cycle", {15'd0, w_wrap}, 16'd0);
    step(0, 1, 16'h0100, 1, 0, 0, 4'b0000, 4'b0000);
    chk("w load clears expired", {15'd0, w_exp}, 16'd0);
    chk("w load 0100", w_dig, 16'h0100);

    // Mid-count clear with TICK held high.
    step(0, 1, 16'h0001, 1, 0, 0, 4'b0000, 4'b0000);
    step(0, 0, 16'h0000, 1, 1, 1, 4'b0000, 4'b0000);
    chk("s expired before clr", {15'd0, s_exp}, 16'd1);
    step(0, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000);
    step(0, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000);
    chk("s count before clr", s_dig, 16'h0002);
    step(1, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000);
    chk("clr digits", s_dig, 16'h0000);
    chk("clr wrap", {15'd0, s_wrap}, 16'd0);
    chk("clr expired", {15'd0, s_exp}, 16'd0);
    chk("clr zero", {15'd0, s_zero}, 16'd1);
    step(0, 0, 16'h0000, 1, 1, 0, 4'b0000, 4'b0000);
    chk("count after clr", s_dig, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
